// File: rtl/du_pkg.sv
// Shared constants and state encoding for the UART word dumper.
package du_pkg;

    localparam int BYTE           = 8;
    localparam int DWORD          = 32;
    localparam int BYTES_PER_WORD = DWORD / BYTE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        WAIT  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/du_tx_dumper.sv
// Reads a run of words from a synchronous word source and streams each one,
// LSB byte first, to a UART transmitter using a start/done-tick handshake.
module du_tx_dumper #(
    parameter int BYTE  = du_pkg::BYTE,
    parameter int DWORD = du_pkg::DWORD,
    parameter int ADDR  = 7
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR-1:0]   i_base_addr,
    input  logic [ADDR:0]     i_count,
    output logic              o_rd_en,
    output logic [ADDR-1:0]   o_rd_addr,
    input  logic [DWORD-1:0]  i_rd_data,
    output logic [BYTE-1:0]   o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done_tick,
    output logic              o_busy,
    output logic              o_done
);

    import du_pkg::*;

    localparam int BPW  = DWORD / BYTE;
    localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [ADDR:0]   CNT_ONE  = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR-1:0] ADDR_ONE = {{(ADDR-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [ADDR-1:0]  addr_r;
    logic [ADDR:0]    rem_r;
    logic [DWORD-1:0] buf_r;
    logic [IDXW-1:0]  idx_r;
    logic [DWORD-1:0] word_s;
    logic [DWORD-1:0] shifted_s;
    logic [IDXW-1:0]  sel_idx_s;
    logic [BYTE-1:0]  sel_byte_s;
    logic [BYTE-1:0]  tx_data_r;
    logic             rd_en_s, tx_start_s, busy_s, done_s;
    logic             rd_en_r, tx_start_r, busy_r, done_r;

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_next_s = (i_count != {(ADDR+1){1'b0}}) ? READ : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:  state_next_s = LATCH;
            LATCH: state_next_s = SEND;
            SEND:  state_next_s = WAIT;
            WAIT: begin
                if (i_tx_done_tick) begin
                    state_next_s = (idx_r == LAST_IDX) ? NEXT : SEND;
                end else begin
                    state_next_s = WAIT;
                end
            end
            NEXT:    state_next_s = (rem_r != CNT_ONE) ? READ : DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Byte mux: on the first byte the word is still on the read bus, later bytes come from the buffer.
    always_comb begin
        if (state_r == LATCH) begin
            word_s    = i_rd_data;
            sel_idx_s = {IDXW{1'b0}};
        end else begin
            word_s    = buf_r;
            sel_idx_s = idx_r + IDX_ONE;
        end
        shifted_s  = word_s >> (int'(sel_idx_s) * BYTE);
        sel_byte_s = shifted_s[BYTE-1:0];
    end

    // Output decode; strobes follow the state being entered so they line up with it once registered.
    always_comb begin
        rd_en_s    = (state_next_s == READ);
        tx_start_s = (state_next_s == SEND);
        busy_s     = (state_next_s != IDLE);
        done_s     = (state_r == DONE);
    end

    // Address, remaining count, word buffer and byte index.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            addr_r <= {ADDR{1'b0}};
            rem_r  <= {(ADDR+1){1'b0}};
            buf_r  <= {DWORD{1'b0}};
            idx_r  <= {IDXW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        addr_r <= i_base_addr;
                        rem_r  <= i_count;
                    end
                end
                LATCH: begin
                    buf_r <= i_rd_data;
                    idx_r <= {IDXW{1'b0}};
                end
                WAIT: begin
                    if (i_tx_done_tick && (idx_r != LAST_IDX)) begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                NEXT: begin
                    rem_r  <= rem_r - CNT_ONE;
                    addr_r <= addr_r + ADDR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs; tx data is only reloaded when a byte is launched.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_en_r    <= 1'b0;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tx_data_r  <= {BYTE{1'b0}};
        end else begin
            rd_en_r    <= rd_en_s;
            tx_start_r <= tx_start_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            if (tx_start_s) begin
                tx_data_r <= sel_byte_s;
            end
        end
    end

    assign o_rd_en    = rd_en_r;
    assign o_rd_addr  = addr_r;
    assign o_tx_data  = tx_data_r;
    assign o_tx_start = tx_start_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule

// File: tb/tb_du_tx_dumper.sv
// Directed self-checking bench for du_tx_dumper with a word-source and UART responder model.
module tb_du_tx_dumper;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [6:0]  i_base_addr = 7'd0;
    logic [7:0]  i_count = 8'd0;
    logic [31:0] i_rd_data = 32'd0;
    wire         i_tx_done_tick;
    logic        o_rd_en;
    logic [6:0]  o_rd_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    logic auto_tick = 1'b0;
    logic spur_tick = 1'b0;
    assign i_tx_done_tick = auto_tick | spur_tick;

    int checks = 0;
    int errors = 0;
    int n_tx = 0;
    int n_rd = 0;
    int n_done = 0;
    int mem_mode = 0;
    logic [7:0] tx_log [0:2047];
    logic [6:0] addr_log [0:2047];

    du_tx_dumper #(.BYTE(8), .DWORD(32), .ADDR(7)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_count(i_count),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done_tick(i_tx_done_tick),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        if (mem_mode == 0) return 32'hDEADBEEF;
        return 32'h11223300 + {25'd0, a};
    endfunction

    // Word source (data valid exactly one cycle after the strobe), UART model and event logger.
    initial begin : responder
        int uart_cnt;
        logic rd_pend;
        logic [6:0] pend_addr;
        uart_cnt = 0;
        rd_pend = 1'b0;
        pend_addr = 7'd0;
        forever begin
            @(posedge i_clock);
            #1;
            if (o_tx_start && n_tx < 2048) begin
                tx_log[n_tx] = o_tx_data;
                n_tx++;
            end
            if (o_rd_en && n_rd < 2048) begin
                addr_log[n_rd] = o_rd_addr;
                n_rd++;
            end
            if (o_done) n_done++;
            i_rd_data = rd_pend ? mem_word(pend_addr) : 32'hA5A5A5A5;
            rd_pend = o_rd_en;
            pend_addr = o_rd_addr;
            auto_tick = 1'b0;
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) auto_tick = 1'b1;
            end
            if (o_tx_start) uart_cnt = 10;
            if (!i_reset) begin
                uart_cnt = 0;
                rd_pend = 1'b0;
                auto_tick = 1'b0;
            end
        end
    end

    task automatic kick(input logic [6:0] base, input logic [7:0] cnt);
        @(negedge i_clock);
        i_base_addr = base;
        i_count = cnt;
        i_start = 1'b1;
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge i_clock);
            #1;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({o_rd_en, o_tx_start, o_busy, o_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {o_rd_en, o_tx_start, o_busy, o_done});
        end
        checks++;
        if (o_rd_addr !== 7'd0 || o_tx_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got addr %h data %h expected 00 00", o_rd_addr, o_tx_data);
        end
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int tx0, rd0, d0;
        bit ok;
        mem_mode = 0;
        tx0 = n_tx; rd0 = n_rd; d0 = n_done;
        kick(7'd5, 8'd1);
        checks++;
        if (o_rd_en !== 1'b1 || o_rd_addr !== 7'd5 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rd_latency: got en %b addr %0d busy %b expected 1 5 1", o_rd_en, o_rd_addr, o_busy);
        end
        @(posedge i_clock); #1;
        checks++;
        if (o_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL single_rd_pulse: got %b expected 0", o_rd_en);
        end
        @(posedge i_clock); #1;
        checks++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'hEF) begin
            errors++;
            $display("FAIL single_tx_latency: got start %b data %h expected 1 ef", o_tx_start, o_tx_data);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done %b busy %b expected 1 0", ok, o_busy);
        end
        @(posedge i_clock); #1;
        checks++;
        if (o_done !== 1'b0 || n_done - d0 !== 1) begin
            errors++;
            $display("FAIL single_done_pulse: got done %b count %0d expected 0 1", o_done, n_done - d0);
        end
        checks++;
        if (n_tx - tx0 !== 4 || n_rd - rd0 !== 1) begin
            errors++;
            $display("FAIL single_counts: got tx %0d rd %0d expected 4 1", n_tx - tx0, n_rd - rd0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_log[tx0 + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL single_byte%0d: got %h expected %h", i, tx_log[tx0 + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_multi_word();
        logic [7:0] exp_b [12] = '{8'h00, 8'h33, 8'h22, 8'h11, 8'h01, 8'h33, 8'h22, 8'h11,
                                   8'h02, 8'h33, 8'h22, 8'h11};
        int tx0, rd0;
        bit ok;
        mem_mode = 1;
        tx0 = n_tx; rd0 = n_rd;
        kick(7'd0, 8'd3);
        wait_done(1000, ok);
        @(posedge i_clock); #1;
        checks++;
        if (!ok || n_tx - tx0 !== 12 || n_rd - rd0 !== 3) begin
            errors++;
            $display("FAIL multi_counts: got done %b tx %0d rd %0d expected 1 12 3", ok, n_tx - tx0, n_rd - rd0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_log[rd0 + i] !== 7'(i)) begin
                errors++;
                $display("FAIL multi_addr%0d: got %0d expected %0d", i, addr_log[rd0 + i], i);
            end
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (tx_log[tx0 + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL multi_byte%0d: got %h expected %h", i, tx_log[tx0 + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_wrap_full();
        int tx0, rd0, d0;
        logic [6:0] exp_a;
        bit ok;
        mem_mode = 1;
        tx0 = n_tx; rd0 = n_rd; d0 = n_done;
        kick(7'd126, 8'd128);
        wait_done(10000, ok);
        @(posedge i_clock); #1;
        checks++;
        if (!ok || n_tx - tx0 !== 512 || n_rd - rd0 !== 128 || n_done - d0 !== 1) begin
            errors++;
            $display("FAIL wrap_counts: got done %b tx %0d rd %0d dn %0d expected 1 512 128 1",
                     ok, n_tx - tx0, n_rd - rd0, n_done - d0);
        end
        exp_a = 7'd126;
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (addr_log[rd0 + i] !== exp_a) begin
                errors++;
                $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addr_log[rd0 + i], exp_a);
            end
            exp_a = exp_a + 7'd1;
        end
        checks++;
        if (tx_log[tx0] !== 8'h7E || tx_log[tx0 + 4] !== 8'h7F || tx_log[tx0 + 8] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_bytes: got %h %h %h expected 7e 7f 00", tx_log[tx0], tx_log[tx0 + 4], tx_log[tx0 + 8]);
        end
    endtask

    task automatic test_zero_count();
        int tx0, rd0;
        tx0 = n_tx; rd0 = n_rd;
        kick(7'd9, 8'd0);
        checks++;
        if (o_rd_en !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_n1: got en %b done %b busy %b expected 0 0 1", o_rd_en, o_done, o_busy);
        end
        @(posedge i_clock); #1;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_n2_done: got done %b busy %b expected 1 0", o_done, o_busy);
        end
        repeat (5) @(posedge i_clock);
        #1;
        checks++;
        if (n_tx !== tx0 || n_rd !== rd0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet: got tx %0d rd %0d done %b expected 0 0 0", n_tx - tx0, n_rd - rd0, o_done);
        end
    endtask

    task automatic test_robustness();
        logic [7:0] exp_b [8] = '{8'h0A, 8'h33, 8'h22, 8'h11, 8'h0B, 8'h33, 8'h22, 8'h11};
        int tx0, rd0, d0;
        bit ok;
        mem_mode = 1;
        tx0 = n_tx; rd0 = n_rd; d0 = n_done;
        kick(7'd10, 8'd2);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge i_clock);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            i_start = o_rd_en | o_tx_start;
            spur_tick = o_rd_en | o_tx_start;
            i_base_addr = 7'h55;
            i_count = 8'd1;
        end
        i_start = 1'b0;
        spur_tick = 1'b0;
        repeat (5) @(posedge i_clock);
        #1;
        checks++;
        if (!ok || o_busy !== 1'b0 || n_tx - tx0 !== 8 || n_rd - rd0 !== 2 || n_done - d0 !== 1) begin
            errors++;
            $display("FAIL robust_counts: got done %b busy %b tx %0d rd %0d dn %0d expected 1 0 8 2 1",
                     ok, o_busy, n_tx - tx0, n_rd - rd0, n_done - d0);
        end
        checks++;
        if (addr_log[rd0] !== 7'd10 || addr_log[rd0 + 1] !== 7'd11) begin
            errors++;
            $display("FAIL robust_addr: got %0d %0d expected 10 11", addr_log[rd0], addr_log[rd0 + 1]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_log[tx0 + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL robust_byte%0d: got %h expected %h", i, tx_log[tx0 + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int tx0, d0, tx1, rd1;
        bit ok;
        mem_mode = 0;
        tx0 = n_tx; d0 = n_done;
        kick(7'd3, 8'd2);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge i_clock); #2;
            if (n_tx - tx0 >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge i_clock);
        #3;
        i_reset = 1'b0;
        #1;
        checks++;
        if (!ok || {o_rd_en, o_tx_start, o_busy, o_done} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_strobes: got reached %b flags %b expected 1 0000", ok, {o_rd_en, o_tx_start, o_busy, o_done});
        end
        checks++;
        if (o_rd_addr !== 7'd0 || o_tx_data !== 8'd0) begin
            errors++;
            $display("FAIL midreset_data: got addr %h data %h expected 00 00", o_rd_addr, o_tx_data);
        end
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        repeat (30) @(posedge i_clock);
        #1;
        checks++;
        if (n_done !== d0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abandon: got done count %0d busy %b expected 0 0", n_done - d0, o_busy);
        end
        tx1 = n_tx; rd1 = n_rd;
        kick(7'd1, 8'd1);
        wait_done(200, ok);
        @(posedge i_clock); #1;
        checks++;
        if (!ok || n_tx - tx1 !== 4 || n_rd - rd1 !== 1 || addr_log[rd1] !== 7'd1) begin
            errors++;
            $display("FAIL midreset_resume: got done %b tx %0d rd %0d addr %0d expected 1 4 1 1",
                     ok, n_tx - tx1, n_rd - rd1, addr_log[rd1]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_log[tx1 + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL midreset_byte%0d: got %h expected %h", i, tx_log[tx1 + i], exp_b[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_wrap_full();
        test_zero_count();
        test_robustness();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
